// File: rtl/param_link_pkg.sv
// Shared definitions for the pulse-parameter serial link: frame layout, control
// codes, framer state encoding and the checksum used by both link directions.
package param_link_pkg;

   localparam int FRAME_DATA_BYTES = 4;
   localparam int FRAME_LEN        = 6;

   typedef enum logic [7:0] {
      CTRL_SET_DELAY     = 8'd0,
      CTRL_SET_PERIOD    = 8'd1,
      CTRL_SET_PUMP      = 8'd2,
      CTRL_SET_PROBE     = 8'd3,
      CTRL_TOGGLE_PUMP   = 8'd4,
      CTRL_SET_BACKPULSE = 8'd5,
      CTRL_SET_ATT       = 8'd6
   } ctrl_code_e;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_ARM        = 3'd1,
      ST_WAIT_START = 3'd2,
      ST_WAIT_END   = 3'd3,
      ST_GAP        = 3'd4,
      ST_FINISH     = 3'd5
   } tx_state_e;

   // Byte-wise sum of the payload, wrapping at 8 bits.
   function automatic logic [7:0] frame_checksum(input logic [31:0] data);
      logic [7:0] sum;
      sum = 8'h00;
      for (int k = 0; k < FRAME_DATA_BYTES; k++) begin
         sum = sum + data[8*k +: 8];
      end
      return sum;
   endfunction

endpackage

// File: rtl/param_frame_tx.sv
// Host-bound framer: sends D0..D3, CTRL, CHK through the uart transmit port,
// one byte per handshake, with an idle gap between bytes and a start timeout.
module param_frame_tx
   import param_link_pkg::*;
#(
   parameter int GAP_CYCLES  = 16,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        send,
   input  logic [31:0] send_data,
   input  logic [7:0]  send_ctrl,
   output logic        busy,
   output logic        done,
   output logic        dropped,
   output logic        err,
   output logic        transmit,
   output logic [7:0]  tx_byte,
   input  logic        is_transmitting
);

   localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam int TO_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES);
   localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(ACK_TIMEOUT);
   localparam logic [2:0]       LAST_IDX = 3'(FRAME_LEN - 1);

   tx_state_e        state_reg, state_next;
   logic [31:0]      data_reg, data_next;
   logic [7:0]       ctrl_reg, ctrl_next;
   logic [7:0]       chk_reg, chk_next;
   logic [2:0]       idx_reg, idx_next;
   logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
   logic [TO_W-1:0]  to_cnt_reg, to_cnt_next;
   logic             busy_reg, busy_next;
   logic             done_reg, done_next;
   logic             dropped_reg, dropped_next;
   logic             err_reg, err_next;
   logic             transmit_reg, transmit_next;
   logic [7:0]       tx_byte_reg, tx_byte_next;

   logic [7:0]       frame_bytes [FRAME_LEN];
   logic [7:0]       cur_byte;

   // Frame image built from the shadow registers, not the live inputs.
   genvar gi;
   generate
      for (gi = 0; gi < FRAME_DATA_BYTES; gi++) begin : g_data_bytes
         assign frame_bytes[gi] = data_reg[8*gi +: 8];
      end
   endgenerate
   assign frame_bytes[FRAME_DATA_BYTES]     = ctrl_reg;
   assign frame_bytes[FRAME_DATA_BYTES + 1] = chk_reg;

   always_comb begin
      cur_byte = 8'h00;
      if (idx_reg <= LAST_IDX) begin
         cur_byte = frame_bytes[idx_reg];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (send) state_next = ST_ARM;
         end
         ST_ARM: begin
            if (!is_transmitting) state_next = ST_WAIT_START;
         end
         ST_WAIT_START: begin
            if (is_transmitting)              state_next = ST_WAIT_END;
            else if (to_cnt_reg == TO_LIMIT)  state_next = ST_IDLE;
         end
         ST_WAIT_END: begin
            if (!is_transmitting) begin
               state_next = (idx_reg == LAST_IDX) ? ST_FINISH : ST_GAP;
            end
         end
         ST_GAP: begin
            if (gap_cnt_reg == '0) state_next = ST_ARM;
         end
         ST_FINISH: state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   // Next values for the datapath and the registered outputs.
   always_comb begin
      data_next     = data_reg;
      ctrl_next     = ctrl_reg;
      chk_next      = chk_reg;
      idx_next      = idx_reg;
      gap_cnt_next  = gap_cnt_reg;
      to_cnt_next   = to_cnt_reg;
      busy_next     = busy_reg;
      tx_byte_next  = tx_byte_reg;
      done_next     = 1'b0;
      dropped_next  = 1'b0;
      err_next      = 1'b0;
      transmit_next = 1'b0;

      if (send && state_reg != ST_IDLE) begin
         dropped_next = 1'b1;
      end

      case (state_reg)
         ST_IDLE: begin
            if (send) begin
               data_next = send_data;
               ctrl_next = send_ctrl;
               chk_next  = frame_checksum(send_data);
               idx_next  = 3'd0;
               busy_next = 1'b1;
            end
         end
         ST_ARM: begin
            if (!is_transmitting) begin
               tx_byte_next  = cur_byte;
               transmit_next = 1'b1;
               to_cnt_next   = '0;
            end
         end
         ST_WAIT_START: begin
            if (!is_transmitting) begin
               if (to_cnt_reg == TO_LIMIT) begin
                  err_next  = 1'b1;
                  busy_next = 1'b0;
               end else begin
                  to_cnt_next = to_cnt_reg + 1'b1;
               end
            end
         end
         ST_WAIT_END: begin
            if (!is_transmitting) begin
               if (idx_reg == LAST_IDX) begin
                  done_next = 1'b1;
                  busy_next = 1'b0;
               end else begin
                  idx_next     = idx_reg + 3'd1;
                  gap_cnt_next = GAP_LOAD;
               end
            end
         end
         ST_GAP: begin
            if (gap_cnt_reg != '0) gap_cnt_next = gap_cnt_reg - 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_reg     <= '0;
         ctrl_reg     <= '0;
         chk_reg      <= '0;
         idx_reg      <= '0;
         gap_cnt_reg  <= '0;
         to_cnt_reg   <= '0;
         busy_reg     <= 1'b0;
         done_reg     <= 1'b0;
         dropped_reg  <= 1'b0;
         err_reg      <= 1'b0;
         transmit_reg <= 1'b0;
         tx_byte_reg  <= 8'h00;
      end else begin
         data_reg     <= data_next;
         ctrl_reg     <= ctrl_next;
         chk_reg      <= chk_next;
         idx_reg      <= idx_next;
         gap_cnt_reg  <= gap_cnt_next;
         to_cnt_reg   <= to_cnt_next;
         busy_reg     <= busy_next;
         done_reg     <= done_next;
         dropped_reg  <= dropped_next;
         err_reg      <= err_next;
         transmit_reg <= transmit_next;
         tx_byte_reg  <= tx_byte_next;
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign dropped  = dropped_reg;
   assign err      = err_reg;
   assign transmit = transmit_reg;
   assign tx_byte  = tx_byte_reg;

endmodule

// File: tb/tb_param_frame_tx.sv
// Bench for param_frame_tx: uart responder with byte scoreboard, plus a
// second instance with GAP_CYCLES=0 driven by hand for gap/hold timing.
module tb_param_frame_tx;
   import param_link_pkg::*;

   localparam int GAP         = 16;
   localparam int ACK         = 1024;
   localparam int BYTE_CYCLES = 10;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        send;
   logic [31:0] send_data;
   logic [7:0]  send_ctrl;
   logic        busy, done, dropped, err, transmit;
   logic [7:0]  tx_byte;
   logic        is_transmitting = 1'b0;

   logic        send_g0;
   logic [31:0] send_data_g0;
   logic [7:0]  send_ctrl_g0;
   logic        busy_g0, done_g0, dropped_g0, err_g0, transmit_g0;
   logic [7:0]  tx_byte_g0;
   logic        is_tx_g0;

   int         errors = 0;
   int         checks = 0;
   logic [7:0] sb_q[$];
   bit         uart_dead = 1'b0;
   bit         gap_armed = 1'b0;
   int         gap_cyc = 0;
   int         byte_left = 0;
   logic [7:0] cur_byte = 8'h00;
   int         done_cnt = 0, dropped_cnt = 0, err_cnt = 0;

   always #5 clk = ~clk;

   param_frame_tx #(.GAP_CYCLES(GAP), .ACK_TIMEOUT(ACK)) dut (
      .clk(clk), .rst_n(rst_n), .send(send), .send_data(send_data), .send_ctrl(send_ctrl),
      .busy(busy), .done(done), .dropped(dropped), .err(err), .transmit(transmit),
      .tx_byte(tx_byte), .is_transmitting(is_transmitting)
   );

   param_frame_tx #(.GAP_CYCLES(0), .ACK_TIMEOUT(64)) dut_g0 (
      .clk(clk), .rst_n(rst_n), .send(send_g0), .send_data(send_data_g0), .send_ctrl(send_ctrl_g0),
      .busy(busy_g0), .done(done_g0), .dropped(dropped_g0), .err(err_g0), .transmit(transmit_g0),
      .tx_byte(tx_byte_g0), .is_transmitting(is_tx_g0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // uart responder: 10-cycle bytes; checks each strobed byte against the scoreboard
   // and the byte-end-to-next-strobe distance (WAIT_END exit, GAP+1 cycles, ARM).
   always @(negedge clk) begin
      if (gap_armed) gap_cyc++;
      if (!rst_n || done) gap_armed = 1'b0;
      if (transmit) begin
         if (gap_armed) check("gap", gap_cyc, GAP + 3);
         gap_armed = 1'b0;
         if (!uart_dead) begin
            $display("tx byte %02h", tx_byte);
            if (sb_q.size() == 0) check("sb_extra", 32'(sb_q.size()), 32'd1);
            else                  check("tx_byte", tx_byte, sb_q.pop_front());
            is_transmitting = 1'b1;
            byte_left       = BYTE_CYCLES - 1;
            cur_byte        = tx_byte;
         end
      end else if (is_transmitting) begin
         if (byte_left == 0) begin
            check("tx_hold", tx_byte, cur_byte);
            is_transmitting = 1'b0;
            gap_armed       = 1'b1;
            gap_cyc         = 0;
         end else begin
            byte_left--;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (done)    done_cnt++;
         if (dropped) dropped_cnt++;
         if (err)     err_cnt++;
      end
   end

   task automatic send_req(input logic [31:0] d, input logic [7:0] c, input logic [7:0] exp_chk,
                           input bit push);
      @(negedge clk);
      send = 1'b1; send_data = d; send_ctrl = c;
      if (push) begin
         for (int k = 0; k < 4; k++) sb_q.push_back(d[8*k +: 8]);
         sb_q.push_back(c);
         sb_q.push_back(exp_chk);
      end
      $display("send data=%08h ctrl=%02h", d, c);
      @(negedge clk);
      send = 1'b0; send_data = $urandom; send_ctrl = 8'($urandom);
   endtask

   task automatic wait_done(input string tag);
      int n;
      bit seen;
      int busy_low;
      n = 0; seen = 1'b0; busy_low = 0;
      while (!seen && n < 4000) begin
         @(negedge clk);
         n++;
         if (done) seen = 1'b1;
         else if (!busy) busy_low++;
      end
      check({tag, "_done"}, seen, 1);
      check({tag, "_busy_held"}, busy_low, 0);
      check({tag, "_busy_fin"}, busy, 0);
      $display("frame %s done after %0d cycles", tag, n);
   endtask

   task automatic wait_g0_tx(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!transmit_g0 && n < 50);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int d0, p0, e0, n, hold_tx;
      bit seen;
      logic [7:0] g0_exp [6];
      rst_n = 1'b0; send = 1'b0; send_data = '0; send_ctrl = '0;
      send_g0 = 1'b0; send_data_g0 = '0; send_ctrl_g0 = '0; is_tx_g0 = 1'b0;
      g0_exp = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h05, 8'hEA};

      repeat (3) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_dropped", dropped, 0);
      check("rst_err", err, 0);
      check("rst_transmit", transmit, 0);
      check("rst_tx_byte", tx_byte, 8'h00);
      rst_n = 1'b1;

      // Basic frame with first-byte latency.
      d0 = done_cnt;
      send_req(32'h04030201, CTRL_SET_PERIOD, 8'h0A, 1'b1);
      check("lat_tx_early", transmit, 0);
      check("lat_busy", busy, 1);
      @(negedge clk);
      check("lat_tx", transmit, 1);
      check("lat_d0", tx_byte, 8'h01);
      wait_done("f1");
      repeat (3) @(negedge clk);
      check("f1_done_cnt", done_cnt - d0, 1);
      check("f1_sb_empty", sb_q.size(), 0);

      // Checksum wraps.
      send_req(32'hFFFFFFFF, CTRL_SET_ATT, 8'hFC, 1'b1);
      wait_done("f2");
      repeat (3) @(negedge clk);
      check("f2_sb_empty", sb_q.size(), 0);

      // Send while busy, then send in FINISH (dropped) and the cycle after (accepted).
      d0 = done_cnt; p0 = dropped_cnt;
      send_req(32'h80808080, CTRL_SET_PUMP, 8'h00, 1'b1);
      repeat (2) @(negedge clk);
      send = 1'b1; send_data = 32'h12345678;
      @(negedge clk);
      send = 1'b0;
      wait_done("f3");
      send = 1'b1; send_data = 32'hDEADBEEF; send_ctrl = 8'h07;
      @(negedge clk);
      send_data = 32'h01000000; send_ctrl = CTRL_TOGGLE_PUMP;
      for (int k = 0; k < 4; k++) sb_q.push_back(send_data[8*k +: 8]);
      sb_q.push_back(CTRL_TOGGLE_PUMP);
      sb_q.push_back(8'h01);
      @(negedge clk);
      send = 1'b0;
      wait_done("f4");
      repeat (3) @(negedge clk);
      check("drop_cnt", dropped_cnt - p0, 2);
      check("drop_done_cnt", done_cnt - d0, 2);
      check("f4_sb_empty", sb_q.size(), 0);

      // uart never starts: timeout abort, then a normal frame.
      d0 = done_cnt; e0 = err_cnt;
      uart_dead = 1'b1;
      send_req(32'h55555555, CTRL_SET_PROBE, 8'h54, 1'b0);
      n = 0;
      while (!transmit && n < 10) begin @(negedge clk); n++; end
      check("to_strobe", transmit, 1);
      n = 0;
      do begin @(negedge clk); n++; end while (!err && n < ACK + 10);
      check("to_window", (n >= ACK && n <= ACK + 2), 1);
      check("to_busy", busy, 0);
      repeat (3) @(negedge clk);
      check("to_err_cnt", err_cnt - e0, 1);
      check("to_no_done", done_cnt - d0, 0);
      uart_dead = 1'b0;
      send_req(32'h11223344, CTRL_SET_PROBE, 8'hAA, 1'b1);
      wait_done("f5");
      repeat (3) @(negedge clk);
      check("f5_sb_empty", sb_q.size(), 0);

      // Reset during the strobe of byte 2.
      send_req(32'h04030201, CTRL_SET_PERIOD, 8'h0A, 1'b1);
      n = 0; seen = 1'b0;
      while (!seen && n < 500) begin
         @(posedge clk); #1; n++;
         if (transmit && tx_byte == 8'h03) seen = 1'b1;
      end
      check("rst_mid_found", seen, 1);
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("rst_mid_transmit", transmit, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_tx_byte", tx_byte, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      d0 = done_cnt;
      send_req(32'h000000AA, CTRL_SET_DELAY, 8'hAA, 1'b1);
      wait_done("f6");
      repeat (3) @(negedge clk);
      check("f6_done_cnt", done_cnt - d0, 1);
      check("f6_sb_empty", sb_q.size(), 0);

      // GAP_CYCLES=0 instance: D0 waits for idle, single GAP cycle between bytes.
      @(negedge clk);
      is_tx_g0 = 1'b1;
      send_g0 = 1'b1; send_data_g0 = 32'hA1B2C3D4; send_ctrl_g0 = CTRL_SET_BACKPULSE;
      @(negedge clk);
      send_g0 = 1'b0; send_data_g0 = '0; send_ctrl_g0 = '0;
      hold_tx = 0;
      repeat (6) begin @(negedge clk); if (transmit_g0) hold_tx++; end
      check("g0_hold", hold_tx, 0);
      is_tx_g0 = 1'b0;
      for (int k = 0; k < 6; k++) begin
         wait_g0_tx(n);
         check("g0_gap", n, (k == 0) ? 1 : 3);
         check("g0_byte", tx_byte_g0, g0_exp[k]);
         $display("g0 byte %0d = %02h", k, tx_byte_g0);
         is_tx_g0 = 1'b1;
         repeat (4) @(negedge clk);
         is_tx_g0 = 1'b0;
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!done_g0 && n < 20);
      check("g0_done_lat", n, 1);
      check("g0_busy_fin", busy_g0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
